// File: rtl/noc_linreg_master.sv
// Master endpoint for the linear-regression deviation service: splits one host job
// across NUM_SLAVES engines over a credit-flow-controlled NoC and gathers their results.
module noc_linreg_master #(
  parameter int DATA_W      = 64,
  parameter int DEST_W      = 2,
  parameter int VC_W        = 1,
  parameter int NUM_SLAVES  = 2,
  parameter int SLAVE_W     = 1,
  parameter int SLAVE_BASE  = 2,
  parameter int SEND_VC     = 0,
  parameter int NUM_CREDITS = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              job_valid,
  output logic                              job_ready,
  input  logic [31:0]                       job_start,
  input  logic [31:0]                       job_end,
  output logic [2+DEST_W+VC_W+DATA_W-1:0]   flit_out,
  input  logic [VC_W:0]                     credit_in,
  input  logic [2+DEST_W+VC_W+DATA_W-1:0]   flit_in,
  output logic [VC_W:0]                     credit_out,
  output logic                              res_valid,
  output logic [SLAVE_W-1:0]                res_slave,
  output logic [3:0]                        res_chunk,
  output logic [31:0]                       res_dev,
  output logic                              done,
  output logic                              err,
  output logic                              busy
);

  localparam int FW     = 2 + DEST_W + VC_W + DATA_W;
  localparam int CRED_W = $clog2(NUM_CREDITS + 1);
  localparam int CNT_W  = SLAVE_W + 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_SEND_HEAD = 3'd2;
  localparam logic [2:0] S_SEND_TAIL = 3'd3;
  localparam logic [2:0] S_COLLECT   = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [CRED_W-1:0]  credits_q, credits_d;
  logic [SLAVE_W-1:0] i_q, i_d;
  logic [CNT_W-1:0]   rx_count_q, rx_count_d;
  logic [31:0]        start_q, start_d, end_q, end_d, size_q, size_d, lo_q, lo_d;
  logic [FW-1:0]      flit_q, flit_d;
  logic [VC_W:0]      credit_out_q, credit_out_d;
  logic               res_valid_q, res_valid_d;
  logic [SLAVE_W-1:0] res_slave_q, res_slave_d;
  logic [3:0]         res_chunk_q, res_chunk_d;
  logic [31:0]        res_dev_q, res_dev_d;
  logic               done_q, done_d, err_q, err_d;

  logic               send, credit_inc, last, rx_valid, accept_res;
  logic [31:0]        len, hi;
  logic [DEST_W-1:0]  dest;
  logic [VC_W-1:0]    rx_vc;
  logic [DATA_W-1:0]  rx_data;
  logic               unused_bits;

  assign rx_valid    = flit_in[FW-1];
  assign rx_vc       = flit_in[DATA_W +: VC_W];
  assign rx_data     = flit_in[DATA_W-1:0];
  assign unused_bits = ^{flit_in[FW-2 -: 1+DEST_W], rx_data[DATA_W-SLAVE_W-5:32]};

  assign len        = end_q - start_q + 32'd1;
  assign last       = (i_q == SLAVE_W'(NUM_SLAVES - 1));
  // The last chunk ends at job_end so it absorbs the division remainder.
  assign hi         = last ? end_q : lo_q + size_q - 32'd1;
  assign dest       = DEST_W'(SLAVE_BASE) + DEST_W'(i_q);
  assign credit_inc = credit_in[VC_W] && (credit_in[VC_W-1:0] == VC_W'(SEND_VC));
  assign accept_res = rx_valid && (state_q != S_IDLE) && (state_q != S_ERR);

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    start_d      = start_q;
    end_d        = end_q;
    size_d       = size_q;
    lo_d         = lo_q;
    flit_d       = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    send         = 1'b0;
    credit_out_d = rx_valid ? {1'b1, rx_vc} : '0;
    res_valid_d  = accept_res;
    res_slave_d  = res_slave_q;
    res_chunk_d  = res_chunk_q;
    res_dev_d    = res_dev_q;
    rx_count_d   = rx_count_q;
    if (accept_res) begin
      res_slave_d = rx_data[DATA_W-1 -: SLAVE_W];
      res_chunk_d = rx_data[DATA_W-1-SLAVE_W -: 4];
      res_dev_d   = rx_data[31:0];
      rx_count_d  = rx_count_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        rx_count_d = '0;
        if (job_valid) begin
          start_d = job_start;
          end_d   = job_end;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        size_d = len >> SLAVE_W;
        lo_d   = start_q;
        i_d    = '0;
        if (end_q < start_q || len < 32'(NUM_SLAVES)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = S_SEND_HEAD;
        end
      end
      S_SEND_HEAD: begin
        if (credits_q != '0) begin
          send    = 1'b1;
          flit_d  = {1'b1, 1'b0, dest, VC_W'(SEND_VC), DATA_W'({lo_q, hi})};
          state_d = S_SEND_TAIL;
        end
      end
      S_SEND_TAIL: begin
        if (credits_q != '0) begin
          send   = 1'b1;
          flit_d = {1'b1, 1'b1, dest, VC_W'(SEND_VC), DATA_W'(4'(i_q))};
          if (last) begin
            state_d = S_COLLECT;
          end else begin
            i_d     = i_q + SLAVE_W'(1);
            lo_d    = lo_q + size_q;
            state_d = S_SEND_HEAD;
          end
        end
      end
      S_COLLECT: begin
        if (rx_count_q >= CNT_W'(NUM_SLAVES)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A send and a returned credit in the same cycle cancel; the pool saturates.
    credits_d = credits_q;
    if (send && !credit_inc) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (!send && credit_inc && credits_q < CRED_W'(NUM_CREDITS)) begin
      credits_d = credits_q + CRED_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      credits_q    <= CRED_W'(NUM_CREDITS);
      i_q          <= '0;
      rx_count_q   <= '0;
      start_q      <= '0;
      end_q        <= '0;
      size_q       <= '0;
      lo_q         <= '0;
      flit_q       <= '0;
      credit_out_q <= '0;
      res_valid_q  <= 1'b0;
      res_slave_q  <= '0;
      res_chunk_q  <= '0;
      res_dev_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      i_q          <= i_d;
      rx_count_q   <= rx_count_d;
      start_q      <= start_d;
      end_q        <= end_d;
      size_q       <= size_d;
      lo_q         <= lo_d;
      flit_q       <= flit_d;
      credit_out_q <= credit_out_d;
      res_valid_q  <= res_valid_d;
      res_slave_q  <= res_slave_d;
      res_chunk_q  <= res_chunk_d;
      res_dev_q    <= res_dev_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign job_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign flit_out   = flit_q;
  assign credit_out = credit_out_q;
  assign res_valid  = res_valid_q;
  assign res_slave  = res_slave_q;
  assign res_chunk  = res_chunk_q;
  assign res_dev    = res_dev_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_noc_linreg_master.sv
// Directed scoreboard bench for noc_linreg_master: a default instance plus a
// single-credit instance used to exercise credit stalls.
module tb_noc_linreg_master;

  localparam int FW = 69;

  typedef struct { logic [FW-1:0] f; int c; } fexp_t;
  typedef struct { logic [1:0] v; int c; } cexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic          rst, jv, jv1, jr, jr1;
  logic [31:0]   js, je;
  logic [FW-1:0] flit_out, flit_out1, flit_in, flit_in1;
  logic [1:0]    credit_in, credit_in1, credit_out, credit_out1;
  logic [1:0]    resp_credit, man_credit;
  logic          res_valid, res_valid1, done, done1, err, err1, busy, busy1;
  logic [0:0]    res_slave, res_slave1;
  logic [3:0]    res_chunk, res_chunk1;
  logic [31:0]   res_dev, res_dev1;
  bit            resp_en;

  assign credit_in = resp_credit | man_credit;

  noc_linreg_master u_dut (
    .CLK(clk), .RST(rst), .job_valid(jv), .job_ready(jr), .job_start(js), .job_end(je),
    .flit_out(flit_out), .credit_in(credit_in), .flit_in(flit_in), .credit_out(credit_out),
    .res_valid(res_valid), .res_slave(res_slave), .res_chunk(res_chunk), .res_dev(res_dev),
    .done(done), .err(err), .busy(busy)
  );

  noc_linreg_master #(.NUM_CREDITS(1)) u_c1 (
    .CLK(clk), .RST(rst), .job_valid(jv1), .job_ready(jr1), .job_start(js), .job_end(je),
    .flit_out(flit_out1), .credit_in(credit_in1), .flit_in(flit_in1), .credit_out(credit_out1),
    .res_valid(res_valid1), .res_slave(res_slave1), .res_chunk(res_chunk1), .res_dev(res_dev1),
    .done(done1), .err(err1), .busy(busy1)
  );

  fexp_t       qm[$], q1[$];
  cexp_t       qc[$];
  logic [36:0] qr[$];
  int          due[$];
  int          outstanding = 0;
  fexp_t       em, e1;
  cexp_t       ec;
  logic [36:0] er;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mkf(input logic tail, input logic [1:0] dest, input logic [63:0] data);
    return {1'b1, tail, dest, 1'b0, data};
  endfunction

  // Main-instance monitors: flits, results, returned credits.
  always @(negedge clk) begin
    resp_credit = (resp_en && flit_out[FW-1]) ? 2'b10 : 2'b00;
    if (flit_out[FW-1]) begin
      if (qm.size() == 0) chk("unexpected_flit", flit_out, '0);
      else begin
        em = qm.pop_front();
        chk("flit", flit_out, em.f);
        if (em.c >= 0) chk("flit_cycle", cyc, em.c);
      end
    end
    if (res_valid) begin
      if (qr.size() == 0) chk("unexpected_res", res_valid, 1'b0);
      else begin
        er = qr.pop_front();
        chk("res", {res_slave, res_chunk, res_dev}, er);
      end
    end
    if (credit_out[1]) begin
      if (qc.size() == 0) chk("unexpected_credit", credit_out, 2'b00);
      else begin
        ec = qc.pop_front();
        chk("credit_out", credit_out, ec.v);
        chk("credit_cycle", cyc, ec.c);
      end
    end
  end

  // Single-credit instance: return each credit 5 cycles after its flit.
  always @(negedge clk) begin
    credit_in1 = 2'b00;
    if (due.size() != 0 && due[0] == cyc) begin
      void'(due.pop_front());
      credit_in1 = 2'b10;
      outstanding--;
    end
    if (flit_out1[FW-1]) begin
      chk("c1_outstanding", outstanding, 0);
      if (q1.size() == 0) chk("c1_unexpected_flit", flit_out1, '0);
      else begin
        e1 = q1.pop_front();
        chk("c1_flit", flit_out1, e1.f);
      end
      outstanding++;
      due.push_back(cyc + 5);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic job(input logic [31:0] s, input logic [31:0] e, output int t);
    js = s; je = e; jv = 1'b1; t = cyc;
    tick;
    jv = 1'b0;
  endtask

  task automatic exp4(input bit c1, input logic [31:0] lo0, input logic [31:0] hi0,
                      input logic [31:0] lo1, input logic [31:0] hi1, input int t0);
    fexp_t x[4];
    x[0].f = mkf(1'b0, 2'd2, {lo0, hi0});
    x[1].f = mkf(1'b1, 2'd2, 64'd0);
    x[2].f = mkf(1'b0, 2'd3, {lo1, hi1});
    x[3].f = mkf(1'b1, 2'd3, 64'd1);
    for (int k = 0; k < 4; k++) begin
      x[k].c = (t0 < 0) ? -1 : t0 + k;
      if (c1) q1.push_back(x[k]); else qm.push_back(x[k]);
    end
  endtask

  task automatic drain_m;
    for (int k = 0; k < 100 && qm.size() != 0; k++) tick;
    chk("drain_main", qm.size(), 0);
  endtask

  task automatic drain_1;
    for (int k = 0; k < 300 && q1.size() != 0; k++) tick;
    chk("drain_c1", q1.size(), 0);
  endtask

  task automatic send_res(input logic s, input logic [3:0] ch, input logic [31:0] dev,
                          input logic vc, input bit exp_res);
    cexp_t x;
    flit_in = {1'b1, 1'b0, 2'b00, vc, s, ch, 27'd0, dev};
    x.v = {1'b1, vc};
    x.c = cyc + 1;
    qc.push_back(x);
    if (exp_res) qr.push_back({s, ch, dev});
    tick;
    flit_in = '0;
  endtask

  task automatic chk_done_seq;
    chk("done_early", done, 1'b0);
    tick;
    chk("done_pulse", done, 1'b1);
    tick;
    chk("done_clear", done, 1'b0);
    chk("ready_after_done", jr, 1'b1);
  endtask

  task automatic chk_reset;
    chk("rst_flit_out", flit_out, '0);
    chk("rst_credit_out", credit_out, 2'b00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_slave", res_slave, 1'b0);
    chk("rst_res_chunk", res_chunk, 4'd0);
    chk("rst_res_dev", res_dev, 32'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_job_ready", jr, 1'b1);
  endtask

  task automatic bad_job(input logic [31:0] s, input logic [31:0] e);
    int t;
    job(s, e, t);
    chk("rej_err_t1", err, 1'b0);
    chk("rej_busy_t1", busy, 1'b1);
    tick;
    chk("rej_err_t2", err, 1'b1);
    chk("rej_ready_t2", jr, 1'b0);
    tick;
    chk("rej_err_t3", err, 1'b0);
    chk("rej_ready_t3", jr, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; jv = 1'b0; jv1 = 1'b0; js = '0; je = '0;
    flit_in = '0; flit_in1 = '0; man_credit = 2'b00; resp_en = 1'b1;
    tick; tick;
    chk_reset;
    rst = 1'b0;
    tick;

    // Even split, four back-to-back flits from T+3, then results in reverse order.
    job(32'd0, 32'd99, t);
    $display("job start=0 end=99 at cycle %0d", t);
    exp4(1'b0, 32'd0, 32'd49, 32'd50, 32'd99, t + 3);
    drain_m;
    send_res(1'b1, 4'd1, 32'h1234, 1'b0, 1'b1);
    send_res(1'b0, 4'd0, 32'h0042, 1'b0, 1'b1);
    chk_done_seq;

    // Uneven range: the last chunk takes the remainder.
    job(32'd10, 32'd16, t);
    $display("job start=10 end=16 at cycle %0d", t);
    exp4(1'b0, 32'd10, 32'd12, 32'd13, 32'd16, t + 3);
    drain_m;
    send_res(1'b0, 4'd0, 32'h0007, 1'b0, 1'b1);
    send_res(1'b1, 4'd1, 32'h0009, 1'b0, 1'b1);
    chk_done_seq;

    $display("rejected job start=9 end=5");
    bad_job(32'd9, 32'd5);
    $display("rejected job start=7 end=7");
    bad_job(32'd7, 32'd7);

    // Single-credit instance: one flit outstanding at a time.
    js = 32'd0; je = 32'd99; jv1 = 1'b1;
    tick;
    jv1 = 1'b0;
    $display("c1 job start=0 end=99");
    exp4(1'b1, 32'd0, 32'd49, 32'd50, 32'd99, -1);
    drain_1;

    // Use up all credits, then stall a job and reset it in the middle of SEND_TAIL.
    resp_en = 1'b0;
    job(32'd0, 32'd99, t);
    $display("credit-draining job at cycle %0d", t);
    exp4(1'b0, 32'd0, 32'd49, 32'd50, 32'd99, t + 3);
    drain_m;
    send_res(1'b1, 4'd1, 32'h0001, 1'b0, 1'b1);
    send_res(1'b0, 4'd0, 32'h0002, 1'b0, 1'b1);
    chk_done_seq;

    job(32'd0, 32'd99, t);
    $display("stalled job at cycle %0d", t);
    begin
      fexp_t x;
      x.f = mkf(1'b0, 2'd2, {32'd0, 32'd49});
      x.c = -1;
      qm.push_back(x);
    end
    repeat (6) tick;
    chk("stall_hold", qm.size(), 1);
    man_credit = 2'b10;
    tick;
    man_credit = 2'b00;
    drain_m;
    tick;
    chk("busy_in_tail", busy, 1'b1);
    rst = 1'b1;
    tick;
    $display("reset during SEND_TAIL at cycle %0d", cyc);
    chk_reset;
    rst = 1'b0;
    tick;

    // Late result in IDLE: credited back, not reported.
    send_res(1'b0, 4'd0, 32'hdead, 1'b1, 1'b0);
    tick; tick;

    // Full credit pool after reset: four flits without any returns.
    job(32'd0, 32'd99, t);
    $display("post-reset job at cycle %0d", t);
    exp4(1'b0, 32'd0, 32'd49, 32'd50, 32'd99, t + 3);
    drain_m;
    repeat (3) tick;
    chk("res_queue_empty", qr.size(), 0);
    chk("credit_queue_empty", qc.size(), 0);
    chk("c1_queue_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
